// File: rtl/parity_nibble_tx_if.sv
// Word handshake into the nibble link transmitter.
// master drives the word, slave answers ready.
interface parity_nibble_tx_if;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/parity_nibble_tx.sv
// Serial transmitter for the parity-protected nibble link.
// Frame: start, d0..d3, p0, p1, stop; CLKS_PER_BIT clocks per slot.
module parity_nibble_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  parity_nibble_tx_if.slave up,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              frame_done
);

  localparam int DW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DW-1:0] DIV_LAST =
    DW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t        state;
  logic [DW-1:0] div;
  logic [1:0]    bit_cnt;
  logic [5:0]    shreg;
  logic          slot_end;
  logic          accept;
  logic          last_next;
  logic          p0;
  logic          p1;

  assign up.in_ready = (state == IDLE) && !rst;
  assign accept      = up.in_valid && up.in_ready;
  assign slot_end    = (div == DIV_LAST);
  assign p0 = up.in_data[0] ^ up.in_data[1];
  assign p1 = up.in_data[0] ^ up.in_data[2]
            ^ up.in_data[3];

  // frame_done is registered, so flag the cycle
  // before the last stop-slot cycle
  if (CLKS_PER_BIT == 1) begin : g_one
    assign last_next = (state == PAR)
                    && (bit_cnt == 2'd1);
  end else begin : g_many
    localparam logic [DW-1:0] DIV_PEN =
      DW'(CLKS_PER_BIT - 2);
    assign last_next = (state == STOP)
                    && (div == DIV_PEN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div        <= '0;
      bit_cnt    <= 2'd0;
      shreg      <= 6'd0;
      tx_out     <= 1'b1;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_next;
      if (state != IDLE) begin
        div <= slot_end ? '0 : div + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            state   <= START;
            shreg   <= {p1, p0, up.in_data};
            tx_out  <= 1'b0;
            tx_busy <= 1'b1;
            div     <= '0;
            bit_cnt <= 2'd0;
          end
        end
        START: begin
          if (slot_end) begin
            state  <= DATA;
            tx_out <= shreg[0];
            shreg  <= {1'b0, shreg[5:1]};
          end
        end
        DATA: begin
          if (slot_end) begin
            tx_out  <= shreg[0];
            shreg   <= {1'b0, shreg[5:1]};
            bit_cnt <= bit_cnt + 2'd1;
            if (bit_cnt == 2'd3) begin
              state <= PAR;
            end
          end
        end
        PAR: begin
          if (slot_end) begin
            if (bit_cnt == 2'd1) begin
              state   <= STOP;
              tx_out  <= 1'b1;
              bit_cnt <= 2'd0;
            end else begin
              tx_out  <= shreg[0];
              shreg   <= {1'b0, shreg[5:1]};
              bit_cnt <= bit_cnt + 2'd1;
            end
          end
        end
        STOP: begin
          if (slot_end) begin
            state   <= IDLE;
            tx_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_nibble_tx.sv
// Bench for parity_nibble_tx: four instances at
// CLKS_PER_BIT 4, 1, 2, 255 checked against a frame model.
module tb_parity_nibble_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam int CPB [4] = '{4, 1, 2, 255};

  logic [3:0] rst;
  logic [3:0] valid;
  logic [3:0] data [4];
  wire  [3:0] tx;
  wire  [3:0] busy;
  wire  [3:0] done;
  wire  [3:0] rdy;

  parity_nibble_tx_if if0 ();
  parity_nibble_tx_if if1 ();
  parity_nibble_tx_if if2 ();
  parity_nibble_tx_if if3 ();

  assign if0.in_valid = valid[0];
  assign if0.in_data  = data[0];
  assign rdy[0]       = if0.in_ready;
  assign if1.in_valid = valid[1];
  assign if1.in_data  = data[1];
  assign rdy[1]       = if1.in_ready;
  assign if2.in_valid = valid[2];
  assign if2.in_data  = data[2];
  assign rdy[2]       = if2.in_ready;
  assign if3.in_valid = valid[3];
  assign if3.in_data  = data[3];
  assign rdy[3]       = if3.in_ready;

  parity_nibble_tx #(.CLKS_PER_BIT(4)) u0 (
    .clk(clk), .rst(rst[0]), .up(if0.slave),
    .tx_out(tx[0]), .tx_busy(busy[0]),
    .frame_done(done[0]));
  parity_nibble_tx #(.CLKS_PER_BIT(1)) u1 (
    .clk(clk), .rst(rst[1]), .up(if1.slave),
    .tx_out(tx[1]), .tx_busy(busy[1]),
    .frame_done(done[1]));
  parity_nibble_tx #(.CLKS_PER_BIT(2)) u2 (
    .clk(clk), .rst(rst[2]), .up(if2.slave),
    .tx_out(tx[2]), .tx_busy(busy[2]),
    .frame_done(done[2]));
  parity_nibble_tx #(.CLKS_PER_BIT(255)) u3 (
    .clk(clk), .rst(rst[3]), .up(if3.slave),
    .tx_out(tx[3]), .tx_busy(busy[3]),
    .frame_done(done[3]));

  typedef struct {
    logic [3:0] d;
    logic [1:0] par;
  } vec_t;

  vec_t tab [16];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // slot s of the frame for word d: start, data, checks, stop
  function automatic logic [7:0] frame_of(input int d);
    int b0, b1, b2, b3, q0, q1;
    b0 = d % 2;
    b1 = (d / 2) % 2;
    b2 = (d / 4) % 2;
    b3 = (d / 8) % 2;
    q0 = (b0 + b1) % 2;
    q1 = (b0 + b2 + b3) % 2;
    return 8'(128 + q1 * 64 + q0 * 32 + (d % 16) * 2);
  endfunction

  task automatic send(input int u,
                      input logic [3:0] d,
                      input bit poke,
                      output logic [7:0] seen,
                      output int n_done);
    int c;
    int w;
    logic [7:0] f;
    c = CPB[u];
    f = frame_of(int'(d));
    seen = 8'd0;
    n_done = 0;
    w = 0;
    @(negedge clk);
    while (!rdy[u] && w < 600) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", 32'(rdy[u]), 32'd1);
    data[u] = d;
    valid[u] = 1'b1;
    @(posedge clk);
    #1;
    valid[u] = 1'b0;
    data[u] = ~d;
    for (int t = 1; t <= 8 * c; t++) begin
      @(negedge clk);
      if ((t - 1) % c == 0) seen[(t - 1) / c] = tx[u];
      chk("tx_bit", 32'(tx[u]), 32'(f[(t - 1) / c]));
      chk("busy", 32'(busy[u]), 32'd1);
      chk("done", 32'(done[u]), 32'(t == 8 * c));
      chk("rdy_in_frame", 32'(rdy[u]), 32'd0);
      if (done[u]) n_done++;
      if (poke) begin
        valid[u] = (t == 3 * c);
        data[u] = 4'hF;
      end
    end
    valid[u] = 1'b0;
    @(negedge clk);
    chk("idle_tx", 32'(tx[u]), 32'd1);
    chk("idle_busy", 32'(busy[u]), 32'd0);
    chk("idle_rdy", 32'(rdy[u]), 32'd1);
    chk("idle_done", 32'(done[u]), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seen;
    logic [7:0] f;
    int nd;
    int n;

    tab[0]  = '{4'h0, 2'b00};
    tab[1]  = '{4'h1, 2'b11};
    tab[2]  = '{4'h2, 2'b01};
    tab[3]  = '{4'h3, 2'b10};
    tab[4]  = '{4'h4, 2'b10};
    tab[5]  = '{4'h5, 2'b01};
    tab[6]  = '{4'h6, 2'b11};
    tab[7]  = '{4'h7, 2'b00};
    tab[8]  = '{4'h8, 2'b10};
    tab[9]  = '{4'h9, 2'b01};
    tab[10] = '{4'hA, 2'b11};
    tab[11] = '{4'hB, 2'b00};
    tab[12] = '{4'hC, 2'b00};
    tab[13] = '{4'hD, 2'b11};
    tab[14] = '{4'hE, 2'b01};
    tab[15] = '{4'hF, 2'b10};

    rst = 4'hF;
    valid = 4'h0;
    for (int i = 0; i < 4; i++) data[i] = 4'h0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", 32'(tx[0]), 32'd1);
      chk("rst_busy", 32'(busy[0]), 32'd0);
      chk("rst_done", 32'(done[0]), 32'd0);
      chk("rst_rdy", 32'(rdy[0]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 4'h0;
    @(negedge clk);
    chk("post_rst_rdy", 32'(rdy[0]), 32'd1);

    send(0, 4'h1, 1'b0, seen, nd);
    chk("frame_0001", 32'(seen), 32'(8'b1110_0010));
    chk("frame_0001_done", 32'(nd), 32'd1);

    send(0, 4'h6, 1'b1, seen, nd);
    chk("poke_done", 32'(nd), 32'd1);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy[0]) n++;
    end
    chk("poke_no_accept", 32'(n), 32'd0);

    @(negedge clk);
    chk("b2b_rdy", 32'(rdy[1]), 32'd1);
    data[1] = tab[0].d;
    valid[1] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      f = frame_of(int'(tab[i].d));
      for (int s = 0; s < 8; s++) begin
        @(negedge clk);
        chk("b2b_tx", 32'(tx[1]), 32'(f[s]));
        chk("b2b_done", 32'(done[1]), 32'(s == 7));
        if (s == 5)
          chk("b2b_p0", 32'(tx[1]), 32'(tab[i].par[0]));
        if (s == 6)
          chk("b2b_p1", 32'(tx[1]), 32'(tab[i].par[1]));
        if (s == 0 && i < 15) data[1] = tab[i + 1].d;
      end
      @(negedge clk);
      chk("b2b_gap_rdy", 32'(rdy[1]), 32'd1);
      chk("b2b_gap_tx", 32'(tx[1]), 32'd1);
      if (i == 15) valid[1] = 1'b0;
    end

    @(negedge clk);
    chk("mid_rdy", 32'(rdy[2]), 32'd1);
    data[2] = 4'h5;
    valid[2] = 1'b1;
    @(posedge clk);
    #1;
    valid[2] = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      chk("mid_busy", 32'(busy[2]), 32'd1);
    end
    @(posedge clk);
    #1;
    rst[2] = 1'b1;
    @(negedge clk);
    chk("mid_rst_rdy", 32'(rdy[2]), 32'd0);
    @(posedge clk);
    #1;
    rst[2] = 1'b0;
    @(negedge clk);
    chk("mid_tx", 32'(tx[2]), 32'd1);
    chk("mid_busy_clr", 32'(busy[2]), 32'd0);
    chk("mid_rdy_back", 32'(rdy[2]), 32'd1);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (done[2]) n++;
    end
    chk("mid_no_done", 32'(n), 32'd0);

    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(2, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), seen, nd);
      chk("rand_done", 32'(nd), 32'd1);
    end

    send(3, 4'hA, 1'b0, seen, nd);
    chk("frame_1010", 32'(seen), 32'(8'b1111_0100));
    chk("frame_1010_done", 32'(nd), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
